// File: rtl/dmem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_pkg
// Description : Shared types for the M-stage data-memory access unit. Holds
//               the access FSM state encoding and the byte-strobe constants.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_access_pkg;

  // Access FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no access outstanding
    REQ  = 2'd1,  // request presented, waiting for addr_ok
    WAIT = 2'd2,  // request accepted, waiting for data_ok
    DONE = 2'd3   // access complete, result held until M advances
  } dmem_state_e;

  localparam logic [3:0] STRB_WORD = 4'b1111;
  localparam logic [3:0] STRB_NONE = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/dmem_access_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_if
// Description : valid/addr_ok/data_ok data-bus bundle.
//   dreq_valid    master->slave  request valid
//   dreq_addr     master->slave  32-bit byte address
//   dreq_strobe   master->slave  byte write enables (all ones = store)
//   dreq_data     master->slave  32-bit write data
//   dresp_addr_ok slave->master  request accepted
//   dresp_data_ok slave->master  response complete
//   dresp_data    slave->master  load data, valid with dresp_data_ok
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_access_if;

  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );

endinterface
`default_nettype wire

// File: rtl/dmem_access.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access
// Description : M-stage data-memory access unit. Converts the M-stage
//               load/store into a valid/addr_ok/data_ok bus transaction,
//               stalls the pipeline until the access completes and holds
//               the load result until the instruction leaves M.
// Ports       :
//   clk        in   pipeline clock
//   resetn     in   asynchronous active-low reset
//   d_validM   in   M-stage instruction is a load or store
//   MemWriteM  in   1 = store, 0 = load
//   ALUOutM    in   effective byte address
//   DataM      in   forwarded store data
//   StallM     in   hazard unit holds M this cycle
//   FlushM     in   hazard unit squashes M this cycle
//   dbus       mst  data-bus request/response bundle
//   dmem_stall out  stall request to the hazard unit
//   ReadDataM  out  load result for the M/W register
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access
  import dmem_access_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         resetn,
  input  wire logic         d_validM,
  input  wire logic         MemWriteM,
  input  wire logic [31:0]  ALUOutM,
  input  wire logic [31:0]  DataM,
  input  wire logic         StallM,
  input  wire logic         FlushM,
  dmem_access_if.master     dbus,
  output logic              dmem_stall,
  output logic [31:0]       ReadDataM
);

  dmem_state_e state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        wr_q;
  logic        disc_q;
  logic [31:0] rdata_q;

  logic        issue;
  logic        discard;

  // A new request leaves IDLE straight from the M-stage inputs so a
  // zero-wait access costs only one stall cycle. Gating with resetn keeps
  // every output at zero while reset is held, whatever M is presenting.
  assign issue   = resetn & (state == IDLE) & d_validM & ~FlushM;

  // A flush arriving in the same cycle as data_ok must discard too.
  assign discard = disc_q | FlushM;

  // Bus request and stall depend only on state, d_validM and FlushM, never
  // on the bus response, so there is no loop through the hazard unit.
  always_comb begin
    dbus.dreq_valid  = issue | (state == REQ);
    dbus.dreq_addr   = issue ? ALUOutM : addr_q;
    dbus.dreq_data   = issue ? DataM   : data_q;
    dbus.dreq_strobe = (issue ? MemWriteM : wr_q) ? STRB_WORD : STRB_NONE;
    dmem_stall       = issue | (state == REQ) | (state == WAIT);
  end

  assign ReadDataM = rdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      wr_q    <= 1'b0;
      disc_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            addr_q <= ALUOutM;
            data_q <= DataM;
            wr_q   <= MemWriteM;
            disc_q <= 1'b0;
            if (dbus.dresp_addr_ok && dbus.dresp_data_ok) begin
              state   <= DONE;
              rdata_q <= dbus.dresp_data;
            end else if (dbus.dresp_addr_ok) begin
              state <= WAIT;
            end else begin
              state <= REQ;
            end
          end
        end

        REQ: begin
          if (FlushM) disc_q <= 1'b1;
          if (dbus.dresp_addr_ok && dbus.dresp_data_ok) begin
            if (discard) begin
              state <= IDLE;
            end else begin
              state   <= DONE;
              rdata_q <= dbus.dresp_data;
            end
          end else if (dbus.dresp_addr_ok) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (FlushM) disc_q <= 1'b1;
          if (dbus.dresp_data_ok) begin
            // A squashed access drains on the bus but never reaches DONE.
            if (discard) begin
              state <= IDLE;
            end else begin
              state   <= DONE;
              rdata_q <= dbus.dresp_data;
            end
          end
        end

        DONE: begin
          // Hold the result until the instruction actually leaves M.
          if (!StallM || FlushM) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access
// Description : Self-checking bench for dmem_access. A driver issues M-stage
//               loads/stores and pushes the expected bus request; a bus
//               model answers with chosen latencies; monitors compare bus
//               requests and the held load result against expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic        d_validM  = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUOutM   = 32'd0;
  logic [31:0] DataM     = 32'd0;
  logic        StallM    = 1'b0;
  logic        FlushM    = 1'b0;
  logic        dmem_stall;
  logic [31:0] ReadDataM;

  dmem_access_if bus();

  dmem_access dut (
    .clk       (clk),
    .resetn    (resetn),
    .d_validM  (d_validM),
    .MemWriteM (MemWriteM),
    .ALUOutM   (ALUOutM),
    .DataM     (DataM),
    .StallM    (StallM),
    .FlushM    (FlushM),
    .dbus      (bus),
    .dmem_stall(dmem_stall),
    .ReadDataM (ReadDataM)
  );

  always #5 clk = ~clk;

  // Expected request plus the latencies and response the bus model uses.
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    int          a;    // cycles from issue to addr_ok
    int          d;    // cycles from addr_ok to data_ok
    logic [31:0] rd;   // data returned with data_ok
  } req_t;

  req_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        cur_wr   = 1'b1;
  logic [31:0] cur_rd   = 32'd0;
  logic [31:0] last_rd  = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- bus responder ----------------
  initial begin : bus_model
    int   ph;
    int   cnt;
    bit   got;
    req_t cur;
    ph = 0;
    cnt = 0;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = 32'd0;
    forever begin
      @(negedge clk);
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      if (!resetn) begin
        ph = 0;
      end else begin
        if (ph == 0 && bus.dreq_valid && exp_q.size() > 0) begin
          cur = exp_q[0];
          cnt = cur.a;
          ph  = 1;
        end
        got = 1'b0;
        if (ph == 1) begin
          if (cnt == 0) begin
            bus.dresp_addr_ok = 1'b1;
            cnt = cur.d;
            ph  = 2;
            got = 1'b1;
          end else begin
            cnt--;
          end
        end
        if (ph == 2) begin
          if (!got) cnt--;
          if (cnt == 0) begin
            bus.dresp_data_ok = 1'b1;
            bus.dresp_data    = cur.rd;
            ph = 0;
          end
        end
      end
    end
  end

  // ---------------- request monitor ----------------
  initial begin : req_monitor
    forever begin
      @(negedge clk); #1;
      if (resetn && bus.dreq_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: got request addr=%h expected none", bus.dreq_addr);
        end else begin
          check32("req_addr",   bus.dreq_addr,              exp_q[0].addr);
          check32("req_data",   bus.dreq_data,              exp_q[0].data);
          check32("req_strobe", {28'd0, bus.dreq_strobe},   {28'd0, exp_q[0].strb});
          if (bus.dresp_addr_ok) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- load result monitor ----------------
  // A live, unflushed instruction with no stall request is sitting in DONE.
  initial begin : result_monitor
    forever begin
      @(negedge clk); #1;
      if (resetn && d_validM && !FlushM && !dmem_stall && !cur_wr)
        check32("load_data", ReadDataM, cur_rd);
    end
  end

  // ---------------- driver ----------------
  // Entered and left just after a rising edge.
  task automatic run_instr(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rd, input int a, input int d, input int hold,
                           input bit flush, input int fk);
    req_t e;
    int   n;
    bit   done;
    int   h;
    e.addr = addr;
    e.strb = wr ? 4'b1111 : 4'b0000;
    e.data = data;
    e.a    = a;
    e.d    = d;
    e.rd   = rd;
    exp_q.push_back(e);
    cur_wr    = wr;
    cur_rd    = rd;
    MemWriteM = wr;
    ALUOutM   = addr;
    DataM     = data;
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      FlushM   = flush && (c == fk);
      d_validM = !(flush && c > fk);
      StallM   = 1'b1;
      @(negedge clk);
      if (c == 0) check32("issue_valid", {31'd0, bus.dreq_valid}, 32'd1);
      if (dmem_stall === 1'b1) n++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: got stall still high after %0d cycles expected release", n);
    end
    check32("stall_cycles", n, a + d + 1);
    if (flush) begin
      FlushM = 1'b0;
      check32("flush_keep", ReadDataM, last_rd);
    end else begin
      last_rd = rd;
      h = 0;
      StallM = (hold > 0);
      while (StallM) begin
        @(posedge clk); #1;
        h++;
        @(negedge clk);
        check32("done_hold_stall", {31'd0, dmem_stall}, 32'd0);
        StallM = (h < hold);
      end
    end
    @(posedge clk); #1;
    d_validM = 1'b0;
    FlushM   = 1'b0;
    StallM   = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check32({tag, "_valid"},  {31'd0, bus.dreq_valid}, 32'd0);
    check32({tag, "_stall"},  {31'd0, dmem_stall},     32'd0);
    check32({tag, "_addr"},   bus.dreq_addr,           32'd0);
    check32({tag, "_data"},   bus.dreq_data,           32'd0);
    check32({tag, "_strobe"}, {28'd0, bus.dreq_strobe}, 32'd0);
    check32({tag, "_rdata"},  ReadDataM,               32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    req_t        e;
    logic        wr;
    int          a, d, hold, fk, gap;
    bit          flush;

    #3;
    check_outputs_zero("reset");
    #9 resetn = 1'b1;
    @(posedge clk); #1;

    // zero-wait load
    run_instr(1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, 0);
    // store with split handshake
    run_instr(1'b1, 32'h0000_0200, 32'h1234_5678, 32'h0, 2, 3, 0, 1'b0, 0);
    // load held in DONE for four cycles
    run_instr(1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1, 1, 4, 1'b0, 0);
    // load flushed while waiting for data_ok
    run_instr(1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_0BAD, 1, 3, 0, 1'b1, 2);
    // back-to-back store then load
    run_instr(1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 32'h0, 0, 1, 0, 1'b0, 0);
    run_instr(1'b0, 32'h0000_0104, 32'h0, 32'h1357_9BDF, 1, 0, 1, 1'b0, 0);

    // reset while a request is outstanding
    e.addr = 32'h0000_0300; e.strb = 4'b1111; e.data = 32'h5555_AAAA;
    e.a = 20; e.d = 0; e.rd = 32'h0;
    exp_q.push_back(e);
    cur_wr = 1'b1;
    MemWriteM = 1'b1; ALUOutM = e.addr; DataM = e.data; d_validM = 1'b1; StallM = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk); #3;
    resetn = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    d_validM = 1'b0;
    StallM   = 1'b0;
    exp_q.delete();
    last_rd = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    resetn = 1'b1;
    @(negedge clk);
    check32("post_reset_stall", {31'd0, dmem_stall}, 32'd0);
    check32("post_reset_valid", {31'd0, bus.dreq_valid}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 80; i++) begin
      wr    = 1'($urandom_range(0, 1));
      a     = int'($urandom_range(0, 3));
      d     = int'($urandom_range(0, 3));
      hold  = int'($urandom_range(0, 3));
      flush = ($urandom_range(0, 4) == 0) && (a + d > 0);
      fk    = (a + d > 0) ? int'($urandom_range(1, a + d)) : 1;
      run_instr(wr, $urandom, $urandom, $urandom, a, d, hold, flush, fk);
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    check32("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
